nn_neuron_mac: RTL and testbench
================================

# nn_neuron_mac

Single-neuron multiply-accumulate engine for the neural-navigator datapath. It sits directly downstream of the pad-level top `tt_um_neural_navigators`, which unpacks `ui_in`/`uio_in` into input/weight beats. The block accumulates `N_INPUTS` products of unsigned activations and signed weights, adds a signed bias, and rescales by an arithmetic right shift. It then applies the activation/saturation stage and returns one 8-bit result per neuron over a valid/ready handshake.

## Interface
- `N_INPUTS`, 8: beats per neuron, range 1–255.
- `ACC_W`, 20: accumulator width. It must be ≥ 17 + clog2(`N_INPUTS`); elaboration fails otherwise.
- `SHIFT`, 4: arithmetic right shift applied after the bias add, range 0–(`ACC_W`-8).
- Ports:
  - `clk` input 1: single clock, rising edge.
  - `rst` input 1: asynchronous, active-high reset. The top drives it as `~rst_n`.
  - `start` input 1: begin a neuron; sampled only in IDLE.
  - `bias` input 8: signed bias, captured when `start` is accepted.
  - `in_valid` input 1: a beat is present on `x`/`w`.
  - `in_ready` output 1: the block accepts a beat this cycle.
  - `x` input 8: unsigned activation.
  - `w` input 8: signed two's-complement weight.
  - `out_valid` output 1: `y` holds a result.
  - `out_ready` input 1: the consumer takes `y`.
  - `y` output 8: activated result.
  - `busy` output 1: high whenever state ≠ IDLE.

## Operation
- States: IDLE, ACCUM, FINISH, OUT.
- IDLE:
  - `start`=1 → ACCUM. Clear `acc`, clear `cnt`, and capture `bias` sign-extended to `ACC_W`.
  - `in_ready`=0.
- ACCUM:
  - `in_ready`=1.
  - On each beat (`in_valid && in_ready`): `acc <= acc + ($signed({1'b0,x}) * $signed(w))`, using a 17-bit signed product sign-extended to `ACC_W`. Then `cnt <= cnt+1`.
  - When the beat with `cnt == N_INPUTS-1` is accepted → FINISH.
- FINISH (1 cycle):
  - `s = (acc + bias_q) >>> SHIFT`, an arithmetic shift that floors toward −∞.
  - `y <= act(s)`, then → OUT.
- OUT:
  - `out_valid`=1 and `y` is held stable.
  - When `out_ready`=1 → IDLE, and `out_valid` drops on that edge.
- `start` outside IDLE is ignored.
- `in_valid` outside ACCUM is ignored; no beat is consumed.
- `acc` cannot overflow given the `ACC_W` rule, so no wrap handling is needed.
- `y` keeps its last value after OUT until the next FINISH.

## Timing
- Reset values: `in_ready`=0, `out_valid`=0, `busy`=0, `y`=0; state IDLE; `acc`, `cnt`, `bias_q` all 0.
- Reset is asynchronous: asserting `rst` mid-operation forces these values immediately. Any partial accumulation is discarded, and the next `start` begins clean.
- `start` is accepted at edge t0. `in_ready` is high from t0 onward.
- One beat is accepted per cycle at most, so the minimum is `N_INPUTS` cycles with back-to-back beats.
- The last beat is accepted at edge tk, giving FINISH in tk..tk+1. `out_valid` rises after edge tk+1.
- Start-to-result minimum latency is `N_INPUTS`+2 edges.
- `out_valid` and `out_ready` high in the same cycle completes the transfer at that edge.
- The earliest next `start` is sampled in the following cycle.
- `start` and `in_valid` asserted together in IDLE: only the start is taken, and the beat must be re-presented.

## Configuration
- `NN_RELU_EN` defined:
  - `act(s)` = 0 if s < 0, 255 if s > 255, else s[7:0].
  - `y` is unsigned.
- `NN_RELU_EN` undefined:
  - `act(s)` = signed saturation to −128..127.
  - `y` is two's complement: 0x80 when s < −128, 0x7F when s > 127.

## Structure
- Package `nn_pkg`:
  - state enum `nn_mac_state_t` (IDLE, ACCUM, FINISH, OUT);
  - `NN_DATA_W`=8;
  - the `ACC_W` legality function.
- Sub-module `nn_act_sat`: combinational `ACC_W`→8 activation/saturation, with the `NN_RELU_EN` switch localized inside it.
- FSM, counter and accumulator live in `nn_neuron_mac`.

## Test plan
All cases use defaults except `N_INPUTS`=4. Expected values are listed as ReLU / no-ReLU.
- **Basic:** `bias`=0; 4 beats of x=16, w=16, back-to-back → `y`=64 / 64. `out_valid` rises exactly one edge after the 4th beat.
- **Negative:** 4 beats of x=100, w=−50; s=−1250 → `y`=0x00 / 0x80.
- **Positive saturation:** 4 beats of x=255, w=127; s=8096 → `y`=0xFF / 0x7F.
- **Bias only and floor:**
  - 4 beats of x=0 with `bias`=80 → `y`=5.
  - With `bias`=−1 → s=−1 → `y`=0 / 0xFF.
- **Stalls and backpressure:**
  - `in_valid` gaps of 3 cycles between beats → same result as back-to-back.
  - Hold `out_ready`=0 for 5 cycles → `y` stable, `in_ready`=0, and a `start` pulse is ignored.
- **Reset mid-ACCUM:** assert `rst` after 2 beats → `in_ready`, `busy` and `out_valid` go 0 without waiting for a clock edge. A fresh neuron then returns the correct `y` with no residue.

Source files
------------

// File: rtl/nn_pkg.sv
// nn_pkg: shared state encoding, data width and accumulator sizing rule for the neuron MAC.
package nn_pkg;
   localparam int NN_DATA_W = 8;
   typedef enum logic [1:0] {IDLE, ACCUM, FINISH, OUT} nn_mac_state_t;
   // 17 bits hold one 9x8 signed product; each doubling of beats needs one more bit.
   function automatic bit nn_acc_w_ok(input int acc_w, input int n_inputs);
      return acc_w >= 17 + $clog2(n_inputs);
   endfunction
endpackage

// File: rtl/nn_act_sat.sv
// nn_act_sat: combinational activation/saturation of the rescaled sum to 8 bits.
// NN_RELU_EN selects unsigned ReLU clamp; otherwise signed saturation to -128..127.
module nn_act_sat
   import nn_pkg::*;
#(
   parameter int ACC_W = 20
) (
   input  logic signed [ACC_W-1:0]     a_i,
   output logic        [NN_DATA_W-1:0] y_o
);
`ifdef NN_RELU_EN
   localparam logic signed [ACC_W-1:0] HI = ACC_W'(255);
   always_comb y_o = a_i[ACC_W-1] ? 8'h00 : (a_i > HI) ? 8'hFF : a_i[7:0];
`else
   localparam logic signed [ACC_W-1:0] HI = ACC_W'(127);
   localparam logic signed [ACC_W-1:0] LO = -ACC_W'(128);
   always_comb y_o = (a_i < LO) ? 8'h80 : (a_i > HI) ? 8'h7F : a_i[7:0];
`endif
endmodule

// File: rtl/nn_neuron_mac.sv
// nn_neuron_mac: accumulates N_INPUTS x*w beats, adds bias, shifts and activates one result
// per neuron over valid/ready. Activation mode chosen by NN_RELU_EN (see nn_act_sat).
module nn_neuron_mac
   import nn_pkg::*;
#(
   parameter int N_INPUTS = 8,
   parameter int ACC_W    = 20,
   parameter int SHIFT    = 4
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        start,
   input  logic signed [NN_DATA_W-1:0] bias,
   input  logic                        in_valid,
   output logic                        in_ready,
   input  logic        [NN_DATA_W-1:0] x,
   input  logic signed [NN_DATA_W-1:0] w,
   output logic                        out_valid,
   input  logic                        out_ready,
   output logic        [NN_DATA_W-1:0] y,
   output logic                        busy
);
   if (!nn_acc_w_ok(ACC_W, N_INPUTS) || SHIFT < 0 || SHIFT > ACC_W - 8 || N_INPUTS < 1 || N_INPUTS > 255) begin : g_bad_cfg
      $error("nn_neuron_mac: illegal N_INPUTS/ACC_W/SHIFT");
   end

   localparam logic [7:0] LAST = 8'(N_INPUTS - 1);

   nn_mac_state_t            state_q;
   logic signed [ACC_W-1:0]  acc_q, acc_d, bias_q, s;
   logic        [7:0]        cnt_q, cnt_d;
   logic        [NN_DATA_W-1:0] y_q, act_y;
   logic signed [16:0]       prod;

   assign prod  = 17'($signed({1'b0, x})) * 17'(w);
   assign acc_d = acc_q + ACC_W'(prod);
   assign cnt_d = cnt_q + 8'd1;
   assign s     = (acc_q + bias_q) >>> SHIFT;

   nn_act_sat #(.ACC_W(ACC_W)) u_act (.a_i(s), .y_o(act_y));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         acc_q   <= '0;
         cnt_q   <= '0;
         bias_q  <= '0;
         y_q     <= '0;
      end else begin
         case (state_q)
            IDLE: if (start) begin
               state_q <= ACCUM;
               acc_q   <= '0;
               cnt_q   <= '0;
               bias_q  <= ACC_W'(bias);
            end
            ACCUM: if (in_valid) begin
               acc_q <= acc_d;
               cnt_q <= cnt_d;
               if (cnt_q == LAST) state_q <= FINISH;
            end
            FINISH: begin
               y_q     <= act_y;
               state_q <= OUT;
            end
            OUT: if (out_ready) state_q <= IDLE;
            default: state_q <= IDLE;
         endcase
      end
   end

   // Handshake flags decode the state register so reset clears them without a clock edge.
   assign in_ready  = state_q == ACCUM;
   assign out_valid = state_q == OUT;
   assign busy      = state_q != IDLE;
   assign y         = y_q;
endmodule

// File: tb/tb_nn_neuron_mac.sv
// tb_nn_neuron_mac: directed test of nn_neuron_mac (N_INPUTS=4) against an arithmetic model.
module tb_nn_neuron_mac;
   localparam int N = 4;
   localparam int SH = 4;
`ifdef NN_RELU_EN
   localparam bit RELU = 1'b1;
`else
   localparam bit RELU = 1'b0;
`endif

   logic clk = 0, rst = 1, start = 0, in_valid = 0, out_ready = 0;
   logic signed [7:0] bias = 0, w = 0;
   logic [7:0] x = 0, y;
   logic in_ready, out_valid, busy;

   int checks = 0, errors = 0, exp_y = 0;
   int xv[N], wv[N];

   nn_neuron_mac #(.N_INPUTS(N), .ACC_W(20), .SHIFT(SH)) dut (
      .clk(clk), .rst(rst), .start(start), .bias(bias), .in_valid(in_valid),
      .in_ready(in_ready), .x(x), .w(w), .out_valid(out_valid),
      .out_ready(out_ready), .y(y), .busy(busy));

   always #5 clk = ~clk;

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   // Model: exact integer dot product, floor division by 2^SHIFT, then clamp.
   function automatic int model_y(input int b);
      int s = b, d = 1 << SH;
      for (int i = 0; i < N; i++) s += xv[i] * wv[i];
      s = (s >= 0) ? s / d : -((-s + d - 1) / d);
      if (RELU) s = (s < 0) ? 0 : (s > 255) ? 255 : s;
      else s = (s < -128) ? -128 : (s > 127) ? 127 : s;
      return s & 255;
   endfunction

   always @(negedge clk) begin
      if (out_valid) chk("y_vs_model", int'(y), exp_y);
   end

   task automatic run(input string nm, input int b, input int gap, input int hold,
                      input bit junk, input int lit_s, input int lit_r);
      exp_y = model_y(b);
      @(negedge clk);
      start = 1; bias = 8'(b);
      if (junk) begin in_valid = 1; x = 200; w = 100; end
      @(negedge clk);
      start = 0; in_valid = 0;
      chk({nm, "_in_ready"}, int'(in_ready), 1);
      chk({nm, "_busy"}, int'(busy), 1);
      for (int i = 0; i < N; i++) begin
         in_valid = 0;
         repeat (gap) @(negedge clk);
         in_valid = 1; x = 8'(xv[i]); w = 8'(wv[i]);
         @(negedge clk);
      end
      in_valid = 0;
      chk({nm, "_ov_finish"}, int'(out_valid), 0);
      @(negedge clk);
      chk({nm, "_ov_rise"}, int'(out_valid), 1);
      chk({nm, "_y"}, int'(y), RELU ? lit_r : lit_s);
      chk({nm, "_in_ready_out"}, int'(in_ready), 0);
      for (int i = 0; i < hold; i++) begin
         start = (i == 2);
         in_valid = (i == 3);
         @(negedge clk);
         chk({nm, "_hold_ov"}, int'(out_valid), 1);
         chk({nm, "_hold_ir"}, int'(in_ready), 0);
      end
      start = 0; in_valid = 0; out_ready = 1;
      @(negedge clk);
      out_ready = 0;
      chk({nm, "_ov_drop"}, int'(out_valid), 0);
      chk({nm, "_idle"}, int'(busy), 0);
   endtask

   initial begin
      repeat (2) @(negedge clk);
      chk("rst_in_ready", int'(in_ready), 0);
      chk("rst_out_valid", int'(out_valid), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_y", int'(y), 0);
      rst = 0;

      xv = '{16, 16, 16, 16};  wv = '{16, 16, 16, 16};
      run("basic", 0, 0, 0, 0, 64, 64);
      xv = '{100, 100, 100, 100};  wv = '{-50, -50, -50, -50};
      run("neg", 0, 0, 0, 0, 8'h80, 0);
      xv = '{255, 255, 255, 255};  wv = '{127, 127, 127, 127};
      run("possat", 0, 0, 0, 0, 8'h7F, 8'hFF);
      xv = '{0, 0, 0, 0};  wv = '{5, -7, 100, -128};
      run("bias80", 80, 0, 0, 0, 5, 5);
      run("biasm1", -1, 0, 0, 0, 8'hFF, 0);
      xv = '{10, 200, 3, 255};  wv = '{-3, 7, -128, 1};
      run("mixed", -20, 0, 0, 0, 76, 76);
      xv = '{16, 16, 16, 16};  wv = '{16, 16, 16, 16};
      run("stall", 0, 3, 5, 0, 64, 64);
      run("start_beat", 0, 0, 0, 1, 64, 64);

      @(negedge clk);
      start = 1; bias = 0;
      @(negedge clk);
      start = 0; in_valid = 1; x = 16; w = 16;
      repeat (2) @(negedge clk);
      in_valid = 0;
      #2 rst = 1;
      #1;
      chk("arst_in_ready", int'(in_ready), 0);
      chk("arst_busy", int'(busy), 0);
      chk("arst_out_valid", int'(out_valid), 0);
      @(negedge clk);
      rst = 0;
      run("after_rst", 0, 0, 0, 0, 64, 64);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
